// File: rtl/mips_isa_pkg.sv
// Shared MIPS ISA definitions: opcodes, loader request kinds and the
// loader FSM state encoding. The control decoder imports the same opcodes.
package mips_isa_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  localparam logic [2:0] KIND_R    = 3'd0;
  localparam logic [2:0] KIND_LW   = 3'd1;
  localparam logic [2:0] KIND_SW   = 3'd2;
  localparam logic [2:0] KIND_BEQ  = 3'd3;
  localparam logic [2:0] KIND_ADDI = 3'd4;
  localparam logic [2:0] KIND_NOP  = 3'd5;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_FULL = 2'd2,
    ST_DONE = 2'd3
  } state_t;

endpackage

// File: rtl/instr_encoder_loader_if.sv
// Request stream (valid/ready + instruction fields) and instruction-memory
// write port of the program loader.
interface instr_encoder_loader_if #(
  parameter int ADDR_W = 8
);
  logic              in_valid;
  logic              in_ready;
  logic [2:0]        in_kind;
  logic [4:0]        in_rs;
  logic [4:0]        in_rt;
  logic [4:0]        in_rd;
  logic [4:0]        in_shamt;
  logic [5:0]        in_funct;
  logic [15:0]       in_imm;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;

  modport slave (
    input  in_valid, in_kind, in_rs, in_rt, in_rd, in_shamt, in_funct, in_imm,
    output in_ready, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output in_valid, in_kind, in_rs, in_rt, in_rd, in_shamt, in_funct, in_imm,
    input  in_ready, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/instr_field_packer.sv
// Combinational packer: request kind + fields -> 32-bit MIPS word.
// o_valid_kind is low for the reserved kinds 6 and 7.
module instr_field_packer
  import mips_isa_pkg::*;
(
  input  logic [2:0]  i_kind,
  input  logic [4:0]  i_rs,
  input  logic [4:0]  i_rt,
  input  logic [4:0]  i_rd,
  input  logic [4:0]  i_shamt,
  input  logic [5:0]  i_funct,
  input  logic [15:0] i_imm,
  output logic [31:0] o_word,
  output logic        o_valid_kind
);

  // Select the instruction format; fields a kind does not use are dropped.
  always_comb begin
    o_word       = 32'h0000_0000;
    o_valid_kind = 1'b1;
    case (i_kind)
      KIND_R:    o_word = {OP_RTYPE, i_rs, i_rt, i_rd, i_shamt, i_funct};
      KIND_LW:   o_word = {OP_LW,    i_rs, i_rt, i_imm};
      KIND_SW:   o_word = {OP_SW,    i_rs, i_rt, i_imm};
      KIND_BEQ:  o_word = {OP_BEQ,   i_rs, i_rt, i_imm};
      KIND_ADDI: o_word = {OP_ADDI,  i_rs, i_rt, i_imm};
      KIND_NOP:  o_word = 32'h0000_0000;
      default:   o_valid_kind = 1'b0;
    endcase
  end

endmodule

// File: rtl/instr_encoder_loader.sv
// Program loader: accepts instruction requests, encodes them and writes the
// words sequentially into instruction memory, one word per cycle.
module instr_encoder_loader
  import mips_isa_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int DEPTH  = 256,
  parameter int ERR_W  = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic                   finish,
  instr_encoder_loader_if.slave  bus,
  output logic [ADDR_W:0]        count,
  output logic [ERR_W-1:0]       err_cnt,
  output logic                   full,
  output logic                   done
);

  localparam logic [ADDR_W:0] LAST_IDX = (ADDR_W+1)'(DEPTH - 1);

  function automatic logic [ERR_W-1:0] sat_inc(input logic [ERR_W-1:0] v);
    return (&v) ? v : v + ERR_W'(1);
  endfunction

  state_t            r_state;
  state_t            w_next_state;
  logic [ADDR_W:0]   r_count;
  logic [ERR_W-1:0]  r_err_cnt;
  logic              r_full;
  logic              r_done;
  logic              r_vld_p1;
  logic [ADDR_W-1:0] r_addr_p1;
  logic [31:0]       r_wdata_p1;

  logic [31:0]       w_word;
  logic              w_valid_kind;
  logic              w_accept;
  logic              w_write;
  logic              w_last;
  logic              w_sess_start;

  instr_field_packer u_packer (
    .i_kind       (bus.in_kind),
    .i_rs         (bus.in_rs),
    .i_rt         (bus.in_rt),
    .i_rd         (bus.in_rd),
    .i_shamt      (bus.in_shamt),
    .i_funct      (bus.in_funct),
    .i_imm        (bus.in_imm),
    .o_word       (w_word),
    .o_valid_kind (w_valid_kind)
  );

  // Ready comes from registered state only, so it never loops back to valid.
  assign bus.in_ready = (r_state == ST_LOAD);
  assign w_accept     = bus.in_valid && bus.in_ready;
  assign w_write      = w_accept && w_valid_kind;
  assign w_last       = w_write && (r_count == LAST_IDX);
  assign w_sess_start = start && ((r_state == ST_IDLE) || (r_state == ST_DONE));

  // FSM state register.
  always_ff @(posedge clk) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_next_state;
  end

  // Next-state logic; finish in LOAD wins over reaching the last address.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE: if (start) w_next_state = ST_LOAD;
      ST_LOAD: begin
        if (finish)      w_next_state = ST_DONE;
        else if (w_last) w_next_state = ST_FULL;
      end
      ST_FULL: if (finish) w_next_state = ST_DONE;
      ST_DONE: if (start)  w_next_state = ST_LOAD;
      default: w_next_state = ST_IDLE;
    endcase
  end

  // ---- stage p0 -> p1: accepted request becomes a registered memory write ----
  // Session counters, flags and the write register. count doubles as the
  // write pointer since both advance only on a valid write.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_count    <= '0;
      r_err_cnt  <= '0;
      r_full     <= 1'b0;
      r_done     <= 1'b0;
      r_vld_p1   <= 1'b0;
      r_addr_p1  <= '0;
      r_wdata_p1 <= '0;
    end else begin
      r_vld_p1 <= w_write;
      r_done   <= (w_next_state == ST_DONE);
      if (w_sess_start) begin
        r_count   <= '0;
        r_err_cnt <= '0;
        r_full    <= 1'b0;
      end
      if (w_write) begin
        r_addr_p1  <= r_count[ADDR_W-1:0];
        r_wdata_p1 <= w_word;
        r_count    <= r_count + (ADDR_W+1)'(1);
      end
      if (w_last) r_full <= 1'b1;
      if (w_accept && !w_valid_kind) r_err_cnt <= sat_inc(r_err_cnt);
    end
  end

  assign bus.mem_we    = r_vld_p1;
  assign bus.mem_addr  = r_addr_p1;
  assign bus.mem_wdata = r_wdata_p1;
  assign count         = r_count;
  assign err_cnt       = r_err_cnt;
  assign full          = r_full;
  assign done          = r_done;

endmodule
